// File: rtl/cic_pkg.sv
// Shared definitions for the CIC configuration controller: FSM state
// encoding, field widths and the legal-decimation-factor check.
package cic_pkg;

    // Decimation factors run from 2^0 to 2^DEC_WIDTH, so the factor field
    // is DEC_WIDTH+1 bits wide.
    localparam int DEC_WIDTH = 4;

    // Width of the flush down-counter (FLUSH_CYCLES tops out at 15).
    localparam int FLUSH_CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_WARMUP = 2'd2
    } cic_state_e;

    // Only the powers of two that the CIC supports are accepted.
    function automatic logic is_legal_dec(input logic [DEC_WIDTH:0] factor);
        logic ok;
        case (factor)
            5'd1, 5'd2, 5'd4, 5'd8, 5'd16: ok = 1'b1;
            default:                       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/cic_rst_seq.sv
// Flush sequencer: holds the CIC reset low for FLUSH_CYCLES cycles after a
// start request. cic_rst_n comes straight from a flop so it cannot glitch.
module cic_rst_seq
    import cic_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic cic_rst_n,
    output logic done
);

    localparam logic [FLUSH_CNT_WIDTH-1:0] LOAD_VAL = FLUSH_CNT_WIDTH'(FLUSH_CYCLES - 1);

    logic [FLUSH_CNT_WIDTH-1:0] cnt_r;

    // Final low cycle of the flush window: the reset is released at the next edge.
    assign done = !cic_rst_n && (cnt_r == {FLUSH_CNT_WIDTH{1'b0}});

    // Down-counter and reset flop; a fresh start always reloads the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= {FLUSH_CNT_WIDTH{1'b0}};
            cic_rst_n <= 1'b0;
        end else if (start) begin
            cnt_r     <= LOAD_VAL;
            cic_rst_n <= 1'b0;
        end else if (!cic_rst_n) begin
            if (cnt_r == {FLUSH_CNT_WIDTH{1'b0}}) begin
                cic_rst_n <= 1'b1;
            end else begin
                cnt_r <= cnt_r - {{(FLUSH_CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/cic_cfg_ctrl.sv
// Configuration controller wrapped around an external CIC decimator.
// Accepts reconfiguration requests, flushes the CIC, discards the warm-up
// outputs and qualifies the result stream.
// Optional feature: define CIC_CTRL_STATUS_EN to add sticky overflow /
// underflow status flags with a clr_status input.
module cic_cfg_ctrl
    import cic_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int Q            = 1,
    parameter int N            = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int RESET_DEC    = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [DEC_WIDTH:0]           cfg_dec_factor,
    input  logic                         cfg_bypass,
    output logic                         cfg_err,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         in_drop,
    output logic                         cic_valid_in,
    output logic [DATA_WIDTH-1:0]        cic_in,
    output logic [DEC_WIDTH:0]           cic_dec_factor,
    output logic                         cic_bypass,
    output logic                         cic_rst_n,
    input  logic                         cic_valid_out,
    input  logic [DATA_WIDTH-1:0]        cic_out,
    input  logic                         cic_overflow,
    input  logic                         cic_underflow,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         busy
`ifdef CIC_CTRL_STATUS_EN
    ,
    input  logic                         clr_status,
    output logic                         sticky_ovf,
    output logic                         sticky_unf
`endif
);

    localparam int WARM_PULSES = Q * N;
    localparam int WARM_W      = (WARM_PULSES > 1) ? $clog2(WARM_PULSES) : 1;
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARM_PULSES - 1);

    cic_state_e        state_r;
    logic [WARM_W-1:0] warm_cnt_r;
    logic              accept_s;
    logic              legal_s;
    logic              change_s;
    logic              start_s;
    logic              flush_done_s;
    logic              run_s;

    assign run_s     = (state_r == ST_RUN);
    assign cfg_ready = run_s;
    assign busy      = !run_s;
    assign accept_s  = cfg_valid && cfg_ready;
    assign legal_s   = is_legal_dec(cfg_dec_factor);
    assign change_s  = (cfg_dec_factor != cic_dec_factor) || (cfg_bypass != cic_bypass);
    assign start_s   = accept_s && legal_s && change_s;

    // Samples reach the CIC except while it is being flushed; those are dropped.
    assign cic_in       = in_data;
    assign cic_valid_in = in_valid && (state_r != ST_FLUSH);
    assign in_drop      = in_valid && (state_r == ST_FLUSH);

    cic_rst_seq #(
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) u_rst_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_s),
        .cic_rst_n (cic_rst_n),
        .done      (flush_done_s)
    );

    // Control FSM with its registered configuration and output qualification.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_RUN;
            warm_cnt_r     <= {WARM_W{1'b0}};
            cic_dec_factor <= (DEC_WIDTH+1)'(RESET_DEC);
            cic_bypass     <= 1'b0;
            cfg_err        <= 1'b0;
            out_valid      <= 1'b0;
            out_data       <= {DATA_WIDTH{1'b0}};
        end else begin
            cfg_err   <= accept_s && !legal_s;
            out_valid <= cic_valid_out && run_s;
            if (cic_valid_out && run_s) begin
                out_data <= cic_out;
            end else begin
                out_data <= out_data;
            end
            case (state_r)
                ST_RUN: begin
                    if (start_s) begin
                        cic_dec_factor <= cfg_dec_factor;
                        cic_bypass     <= cfg_bypass;
                        warm_cnt_r     <= {WARM_W{1'b0}};
                        state_r        <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    // A bypassed CIC has no pipeline to refill.
                    if (flush_done_s) begin
                        state_r <= cic_bypass ? ST_RUN : ST_WARMUP;
                    end
                end
                ST_WARMUP: begin
                    if (cic_valid_out) begin
                        if (warm_cnt_r == WARM_LAST) begin
                            warm_cnt_r <= {WARM_W{1'b0}};
                            state_r    <= ST_RUN;
                        end else begin
                            warm_cnt_r <= warm_cnt_r + {{(WARM_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    state_r <= ST_RUN;
                end
            endcase
        end
    end

`ifdef CIC_CTRL_STATUS_EN
    // Sticky status flags: a set in RUN outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf <= 1'b0;
            sticky_unf <= 1'b0;
        end else begin
            if (run_s && cic_overflow) begin
                sticky_ovf <= 1'b1;
            end else if (clr_status) begin
                sticky_ovf <= 1'b0;
            end else begin
                sticky_ovf <= sticky_ovf;
            end
            if (run_s && cic_underflow) begin
                sticky_unf <= 1'b1;
            end else if (clr_status) begin
                sticky_unf <= 1'b0;
            end else begin
                sticky_unf <= sticky_unf;
            end
        end
    end
`else
    logic unused_status_s;
    assign unused_status_s = cic_overflow ^ cic_underflow;
`endif

endmodule
